// File: rtl/rv_pkg.sv
// Shared RV32I control definitions: immediate formats, opcodes, write-back
// sources, instruction classes and the main controller's state encoding.
package rv_pkg;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_B  = 3'd2,
        IMM_U  = 3'd3,
        IMM_J  = 3'd4,
        IMM_IU = 3'd5,
        IMM_SH = 3'd6
    } imm_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        CLS_R, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH,
        CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC
    } cls_t;

    typedef struct packed {
        cls_t       cls;
        imm_t       imm;
        logic       alu_src_imm;
        logic [1:0] wb_sel;
        logic       writes_rd;
    } dec_t;

    localparam dec_t DEC_NONE = '{cls: CLS_R, imm: IMM_I, alu_src_imm: 1'b0,
                                  wb_sel: WB_ALU, writes_rd: 1'b0};

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct3 classifier feeding the controller's decode registers.
module mc_decode
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output dec_t       dec,
    output logic       illegal
);

    always_comb begin
        dec     = DEC_NONE;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                dec.cls       = CLS_R;
                dec.writes_rd = 1'b1;
            end
            OP_IALU: begin
                dec.cls         = CLS_IALU;
                dec.alu_src_imm = 1'b1;
                dec.writes_rd   = 1'b1;
                // SLTIU sign-extends but compares unsigned; shifts take a 5-bit shamt.
                if (funct3 == 3'b011)
                    dec.imm = IMM_IU;
                else if (funct3 == 3'b001 || funct3 == 3'b101)
                    dec.imm = IMM_SH;
                else
                    dec.imm = IMM_I;
            end
            OP_LOAD: begin
                dec.cls         = CLS_LOAD;
                dec.alu_src_imm = 1'b1;
                dec.wb_sel      = WB_MEM;
                dec.writes_rd   = 1'b1;
            end
            OP_STORE: begin
                dec.cls         = CLS_STORE;
                dec.imm         = IMM_S;
                dec.alu_src_imm = 1'b1;
            end
            OP_BRANCH: begin
                // ALU forms PC + imm as the target; the comparator is separate.
                dec.cls         = CLS_BRANCH;
                dec.imm         = IMM_B;
                dec.alu_src_imm = 1'b1;
            end
            OP_JAL: begin
                dec.cls         = CLS_JAL;
                dec.imm         = IMM_J;
                dec.alu_src_imm = 1'b1;
                dec.wb_sel      = WB_PC4;
                dec.writes_rd   = 1'b1;
            end
            OP_JALR: begin
                dec.cls         = CLS_JALR;
                dec.alu_src_imm = 1'b1;
                dec.wb_sel      = WB_PC4;
                dec.writes_rd   = 1'b1;
            end
            OP_LUI: begin
                dec.cls         = CLS_LUI;
                dec.imm         = IMM_U;
                dec.alu_src_imm = 1'b1;
                dec.wb_sel      = WB_IMM;
                dec.writes_rd   = 1'b1;
            end
            OP_AUIPC: begin
                dec.cls         = CLS_AUIPC;
                dec.imm         = IMM_U;
                dec.alu_src_imm = 1'b1;
                dec.writes_rd   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I main controller: FETCH/DECODE/EXEC/MEM/WB sequencing,
// latched decode fields, retired-instruction counter and sticky trap.
module mc_ctrl
    import rv_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             br_taken,
    output logic             imem_req,
    output logic             ir_en,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             alu_src_imm,
    output logic [2:0]       imm_type,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    dec_t             dec_q, dec_d;
    logic             take_q, take_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    dec_t dec_w;
    logic illegal_w;

    // Only opcode and funct3 steer control; register fields go to the datapath.
    logic unused_inst;
    assign unused_inst = ^{inst[31:15], inst[11:7]};

    mc_decode u_decode (
        .opcode  (inst[6:0]),
        .funct3  (inst[14:12]),
        .dec     (dec_w),
        .illegal (illegal_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dec_q     <= DEC_NONE;
            take_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            take_q    <= take_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dec_d       = dec_q;
        take_d      = take_q;
        retired_d   = retired_q;
        imem_req    = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        halted      = 1'b0;
        imm_type    = dec_q.imm;
        alu_src_imm = dec_q.alu_src_imm;
        wb_sel      = dec_q.wb_sel;
        case (state_q)
            S_IDLE: begin
                imm_type    = IMM_I;
                alu_src_imm = 1'b0;
                wb_sel      = WB_ALU;
                state_d     = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack)
                    state_d = S_DECODE;
            end
            S_DECODE: begin
                dec_d   = dec_w;
                state_d = illegal_w ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (dec_q.cls)
                    CLS_BRANCH:         take_d = br_taken;
                    CLS_JAL, CLS_JALR:  take_d = 1'b1;
                    default:            take_d = 1'b0;
                endcase
                if (dec_q.cls == CLS_LOAD || dec_q.cls == CLS_STORE)
                    state_d = S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (dec_q.cls == CLS_STORE);
                if (dmem_ack)
                    state_d = S_WB;
            end
            S_WB: begin
                rf_we     = dec_q.writes_rd;
                pc_en     = 1'b1;
                pc_sel    = take_q;
                retired_d = retired_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                halted      = 1'b1;
                imm_type    = IMM_I;
                alu_src_imm = 1'b0;
                wb_sel      = WB_ALU;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ir_en   = imem_req & imem_ack;
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: per-instruction timeline model plus a
// per-cycle compare process and a few literal latency/decode checks.
module tb_mc_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   inst = '0;
    logic          imem_ack = 1'b0, dmem_ack = 1'b0, br_taken = 1'b0;
    logic          imem_req, ir_en, pc_en, pc_sel, alu_src_imm;
    logic [2:0]    imm_type;
    logic          dmem_req, dmem_we, rf_we, halted;
    logic [1:0]    wb_sel;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .inst(inst), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .br_taken(br_taken), .imem_req(imem_req), .ir_en(ir_en), .pc_en(pc_en),
        .pc_sel(pc_sel), .alu_src_imm(alu_src_imm), .imm_type(imm_type),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .rf_we(rf_we), .wb_sel(wb_sel),
        .halted(halted), .retired(retired)
    );

    int checks = 0;
    int failures = 0;

    // Expected outputs for the current cycle
    logic          exp_on = 1'b0, e_dec_on = 1'b0;
    logic          e_imem_req, e_ir_en, e_pc_en, e_pc_sel, e_asrc;
    logic          e_dmem_req, e_dmem_we, e_rf_we, e_halted;
    logic [2:0]    e_imm;
    logic [1:0]    e_wb;
    logic [CW-1:0] e_ret;

    // Model state: fields latched at DECODE and the retire count
    logic [2:0]    m_imm = '0;
    logic          m_asrc = 1'b0;
    logic [1:0]    m_wb = '0;
    logic [CW-1:0] m_ret = '0;

    typedef struct {
        logic       legal, mem, store, branch, jump, writes, asrc;
        logic [2:0] imm;
        logic [1:0] wb;
    } ref_t;

    function automatic ref_t ref_decode(input logic [31:0] i);
        ref_t r;
        logic [2:0] f3;
        f3 = i[14:12];
        r.legal = 1'b1; r.mem = 1'b0; r.store = 1'b0; r.branch = 1'b0; r.jump = 1'b0;
        r.writes = 1'b0; r.asrc = 1'b0; r.imm = 3'd0; r.wb = 2'd0;
        case (i[6:0])
            7'h33: r.writes = 1'b1;
            7'h13: begin
                r.writes = 1'b1; r.asrc = 1'b1;
                if (f3 == 3'd3) r.imm = 3'd5;
                else if (f3 == 3'd1 || f3 == 3'd5) r.imm = 3'd6;
            end
            7'h03: begin r.mem = 1'b1; r.writes = 1'b1; r.asrc = 1'b1; r.wb = 2'd1; end
            7'h23: begin r.mem = 1'b1; r.store = 1'b1; r.asrc = 1'b1; r.imm = 3'd1; end
            7'h63: begin r.branch = 1'b1; r.asrc = 1'b1; r.imm = 3'd2; end
            7'h6F: begin r.jump = 1'b1; r.writes = 1'b1; r.asrc = 1'b1; r.imm = 3'd4; r.wb = 2'd2; end
            7'h67: begin r.jump = 1'b1; r.writes = 1'b1; r.asrc = 1'b1; r.wb = 2'd2; end
            7'h37: begin r.writes = 1'b1; r.asrc = 1'b1; r.imm = 3'd3; r.wb = 2'd3; end
            7'h17: begin r.writes = 1'b1; r.asrc = 1'b1; r.imm = 3'd3; end
            default: r.legal = 1'b0;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model's expectation
    always @(negedge clk) begin
        if (exp_on) begin
            chk("imem_req", {31'b0, imem_req}, {31'b0, e_imem_req});
            chk("ir_en",    {31'b0, ir_en},    {31'b0, e_ir_en});
            chk("pc_en",    {31'b0, pc_en},    {31'b0, e_pc_en});
            chk("pc_sel",   {31'b0, pc_sel},   {31'b0, e_pc_sel});
            chk("dmem_req", {31'b0, dmem_req}, {31'b0, e_dmem_req});
            chk("dmem_we",  {31'b0, dmem_we},  {31'b0, e_dmem_we});
            chk("rf_we",    {31'b0, rf_we},    {31'b0, e_rf_we});
            chk("halted",   {31'b0, halted},   {31'b0, e_halted});
            chk("retired",  32'(retired),      32'(e_ret));
            if (e_dec_on) begin
                chk("imm_type",    32'(imm_type),        32'(e_imm));
                chk("alu_src_imm", {31'b0, alu_src_imm}, {31'b0, e_asrc});
                chk("wb_sel",      32'(wb_sel),          32'(e_wb));
            end
        end
    end

    // Observed per-instruction metrics for the literal checks
    int       len_cnt = 0, dm_cnt = 0, last_len = 0, last_dm = 0;
    logic     prev_req = 1'b0, last_psel = 1'b0;
    logic [2:0] last_imm = '0;
    always @(negedge clk) begin
        if (imem_req && !prev_req) begin
            len_cnt = 1; dm_cnt = 0;
        end else begin
            len_cnt++;
        end
        if (dmem_req) dm_cnt++;
        if (pc_en) begin
            last_len = len_cnt; last_dm = dm_cnt; last_imm = imm_type; last_psel = pc_sel;
        end
        prev_req = imem_req;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic base_exp();
        exp_on = 1'b1; e_dec_on = 1'b1;
        e_imem_req = 1'b0; e_ir_en = 1'b0; e_pc_en = 1'b0; e_pc_sel = 1'b0;
        e_dmem_req = 1'b0; e_dmem_we = 1'b0; e_rf_we = 1'b0; e_halted = 1'b0;
        e_imm = m_imm; e_asrc = m_asrc; e_wb = m_wb; e_ret = m_ret;
    endtask

    task automatic stray();
        imem_ack = 1'($urandom); dmem_ack = 1'($urandom); br_taken = 1'($urandom);
    endtask

    task automatic model_clear();
        m_imm = '0; m_asrc = 1'b0; m_wb = '0; m_ret = '0;
    endtask

    task automatic do_reset();
        exp_on = 1'b0;
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        step(); step();
        rst = 1'b0;
        model_clear();
        base_exp();
        step();
    endtask

    task automatic do_inst(input logic [31:0] ins, input int iw, input int dw,
                           input logic br, input logic abort);
        ref_t d;
        logic take;
        d = ref_decode(ins);
        for (int k = 0; k < iw; k++) begin
            base_exp(); e_imem_req = 1'b1;
            stray(); imem_ack = 1'b0; inst = $urandom;
            step();
        end
        base_exp(); e_imem_req = 1'b1; e_ir_en = 1'b1;
        stray(); imem_ack = 1'b1; inst = ins;
        step();
        base_exp(); stray();
        step();
        if (!d.legal) begin
            for (int k = 0; k < 6; k++) begin
                base_exp(); e_dec_on = 1'b0; e_halted = 1'b1;
                stray();
                step();
            end
            return;
        end
        m_imm = d.imm; m_asrc = d.asrc; m_wb = d.wb;
        take = d.jump | (d.branch & br);
        base_exp(); stray(); br_taken = br;
        step();
        if (d.mem) begin
            for (int k = 0; k <= dw; k++) begin
                base_exp(); e_dmem_req = 1'b1; e_dmem_we = d.store;
                stray(); dmem_ack = (k == dw);
                if (abort && k == 1) begin
                    rst = 1'b1; dmem_ack = 1'b0;
                    step();
                    rst = 1'b0;
                    model_clear();
                    base_exp(); stray();
                    step();
                    return;
                end
                step();
            end
        end
        base_exp(); e_rf_we = d.writes; e_pc_en = 1'b1; e_pc_sel = take;
        stray();
        step();
        m_ret = m_ret + 1'b1;
    endtask

    logic [6:0] ops [9];
    logic [31:0] rnd_inst;

    initial begin
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h63;
        ops[5] = 7'h6F; ops[6] = 7'h67; ops[7] = 7'h37; ops[8] = 7'h17;

        do_reset();
        chk("reset_retired", 32'(retired), 32'd0);

        do_inst(32'h00500093, 0, 0, 1'b0, 1'b0);           // ADDI x1,x0,5
        chk("addi_len", last_len, 4);
        chk("addi_imm", 32'(last_imm), 32'd0);
        chk("addi_retired", 32'(retired), 32'd1);

        do_inst(32'h00103093, 1, 0, 1'b0, 1'b0);           // SLTIU
        chk("sltiu_imm", 32'(last_imm), 32'd5);
        do_inst(32'h4020D093, 0, 0, 1'b0, 1'b0);           // SRAI
        chk("srai_imm", 32'(last_imm), 32'd6);

        do_inst(32'h00112223, 0, 3, 1'b0, 1'b0);           // SW, dmem_ack after 3 waits
        chk("sw_len", last_len, 8);
        chk("sw_dmem_cycles", last_dm, 4);

        do_inst(32'h00000463, 0, 0, 1'b1, 1'b0);           // BEQ taken
        chk("beq_taken_pc_sel", {31'b0, last_psel}, 32'd1);
        do_inst(32'h00000463, 0, 0, 1'b0, 1'b0);           // BEQ not taken
        chk("beq_nt_pc_sel", {31'b0, last_psel}, 32'd0);

        for (int n = 0; n < 60; n++) begin
            rnd_inst = {25'($urandom), ops[$urandom_range(0, 8)]};
            do_inst(rnd_inst, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), 1'b0);
        end

        do_inst(32'h00002083, 0, 3, 1'b0, 1'b1);           // LW aborted by reset in MEM
        chk("abort_retired", 32'(retired), 32'd0);
        do_inst(32'h00500093, 0, 0, 1'b0, 1'b0);
        chk("after_abort_retired", 32'(retired), 32'd1);

        do_reset();
        for (int n = 0; n < 15; n++) do_inst(32'h00500093, 0, 0, 1'b0, 1'b0);
        chk("count_full", 32'(retired), 32'd15);
        do_inst(32'h00500093, 0, 0, 1'b0, 1'b0);
        chk("count_wrap", 32'(retired), 32'd0);

        do_inst(32'h0000007F, 0, 0, 1'b0, 1'b0);           // illegal opcode
        chk("trap_halted", {31'b0, halted}, 32'd1);
        do_reset();
        chk("trap_reset_halted", {31'b0, halted}, 32'd0);
        chk("trap_reset_fetch", {31'b0, imem_req}, 32'd1);
        do_inst(32'h00500093, 0, 0, 1'b0, 1'b0);
        chk("post_trap_retired", 32'(retired), 32'd1);

        exp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
